// File: rtl/if_stage_pkg.sv
// Shared encodings for the fetch stage: next-PC selects, fetch FSM states and the NOP word.
`timescale 1ns/1ps
package if_stage_pkg;
  typedef enum logic [1:0] {
    PC_NEXT   = 2'd0,
    PC_JUMP   = 2'd1,
    PC_JR     = 2'd2,
    PC_BRANCH = 2'd3
  } pc_src_t;

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_REQ  = 2'd1,
    F_HOLD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] INST_NOP = 32'h0000_0000;
endpackage

// File: rtl/if_next_pc.sv
// Combinational redirect target and next-PC select; zero latency, no flow control.
`timescale 1ns/1ps
module if_next_pc
  import if_stage_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_inst,
  input  logic [1:0]  pc_src,
  input  logic [31:0] jr_data,
  input  logic        redirect,
  input  logic        redir_pend,
  input  logic [31:0] redir_tgt,
  output logic [31:0] target,
  output logic [31:0] next_pc
);
  logic [31:0] seq;
  logic [31:0] br_off;
  logic        unused_bits;

  assign seq         = id_pc + 32'd4;
  assign br_off      = {{14{id_inst[15]}}, id_inst[15:0], 2'b00};
  assign unused_bits = ^{id_inst[31:26], jr_data[1:0]};

  always_comb begin
    target = seq;
    case (pc_src_t'(pc_src))
      PC_BRANCH: target = seq + br_off;
      PC_JUMP:   target = {seq[31:28], id_inst[25:0], 2'b00};
      PC_JR:     target = {jr_data[31:2], 2'b00};
      default:   target = seq;
    endcase
  end

  // A redirect seen in the same cycle as the delay slot completes wins over a stale pending one.
  always_comb begin
    next_pc = pc + 32'd4;
    if (redirect)
      next_pc = target;
    else if (redir_pend)
      next_pc = redir_tgt;
  end
endmodule

// File: rtl/if_stage.sv
// MIPS IF stage: PC, req/ack fetch FSM with hold buffer, IF/ID register; 1 instr/cycle at zero wait.
// Stalls on if_en&id_en low (ack parked in F_HOLD); optional IF_PERF_CNT_EN adds perf counters.
`timescale 1ns/1ps
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_en,
  input  logic        id_en,
  input  logic        id_rst,
  input  logic [1:0]  pc_src,
  input  logic [31:0] jr_data,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        fetch_stall
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_wait_cnt
`endif
);
  fetch_state_t state, state_nxt;
  logic [31:0]  pc, redir_tgt, hold_inst, target, next_pc;
  logic         redir_pend;
  logic         accept, redirect, load_mem, load_hold, complete, bubble;

  assign accept    = if_en & id_en;
  assign redirect  = accept & id_valid & (pc_src != PC_NEXT);
  assign load_mem  = (state == F_REQ) & imem_ack & accept;
  assign load_hold = (state == F_HOLD) & accept;
  assign complete  = load_mem | load_hold;
  assign bubble    = (state == F_REQ) & ~imem_ack & accept;
  assign imem_addr = pc;

  if_next_pc u_next_pc (
    .pc         (pc),
    .id_pc      (id_pc),
    .id_inst    (id_inst),
    .pc_src     (pc_src),
    .jr_data    (jr_data),
    .redirect   (redirect),
    .redir_pend (redir_pend),
    .redir_tgt  (redir_tgt),
    .target     (target),
    .next_pc    (next_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= F_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    case (state)
      F_IDLE: state_nxt = F_REQ;
      F_REQ: begin
        imem_req = 1'b1;
        if (imem_ack && !accept) state_nxt = F_HOLD;
      end
      F_HOLD: if (accept) state_nxt = F_REQ;
      default: state_nxt = F_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      redir_pend <= 1'b0;
      redir_tgt  <= 32'h0;
      hold_inst  <= INST_NOP;
    end else begin
      if (complete) begin
        pc         <= next_pc;
        redir_pend <= 1'b0;
      end else if (redirect) begin
        redir_pend <= 1'b1;
        redir_tgt  <= target;
      end
      if ((state == F_REQ) && imem_ack && !accept) hold_inst <= imem_rdata;
    end
  end

  // id_rst flushes ID but the fetch itself still completes and advances pc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid    <= 1'b0;
      id_pc       <= 32'h0;
      id_inst     <= INST_NOP;
      fetch_stall <= 1'b0;
    end else begin
      fetch_stall <= bubble & ~id_rst;
      if (id_rst) begin
        id_valid <= 1'b0;
      end else if (load_mem) begin
        id_valid <= 1'b1;
        id_pc    <= pc;
        id_inst  <= imem_rdata;
      end else if (load_hold) begin
        id_valid <= 1'b1;
        id_pc    <= pc;
        id_inst  <= hold_inst;
      end else if (bubble) begin
        id_valid <= 1'b0;
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= 32'h0;
      perf_wait_cnt  <= 32'h0;
    end else begin
      if (complete && !id_rst) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (fetch_stall)         perf_wait_cnt  <= perf_wait_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a variable-latency instruction memory model.
`timescale 1ns/1ps
module tb_if_stage;
  import if_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_en = 1'b1;
  logic        id_en = 1'b1;
  logic        id_rst = 1'b0;
  logic [1:0]  pc_src = 2'd0;
  logic [31:0] jr_data = 32'h0;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        fetch_stall;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_wait_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int lat = 0;
  int wcnt = 0;
  bit mem_on = 1'b1;

  if_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .if_en       (if_en),
    .id_en       (id_en),
    .id_rst      (id_rst),
    .pc_src      (pc_src),
    .jr_data     (jr_data),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .id_valid    (id_valid),
    .id_pc       (id_pc),
    .id_inst     (id_inst),
    .fetch_stall (fetch_stall)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_wait_cnt  (perf_wait_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_at(input logic [31:0] a);
    if (a == 32'h10) return 32'h1000_0003;  // BEQ imm=3
    return 32'h2000_0000 | {16'h0, a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive the memory response for the coming edge, advance one cycle, settle.
  task automatic tick();
    logic req_s;
    if (mem_on) begin
      imem_ack   = imem_req && (wcnt >= lat);
      imem_rdata = imem_ack ? inst_at(imem_addr) : 32'h0;
    end
    req_s = imem_req;
    assert (!(dut.redir_pend && if_en && id_en && id_valid && pc_src != 2'd0)) else begin
      errors++;
      $error("FAIL second_redirect observed=1 expected=0");
    end
    @(posedge clk);
    #1;
    if (mem_on) begin
      if (req_s && imem_ack) wcnt = 0;
      else if (req_s)        wcnt++;
    end
  endtask

  initial begin
    // Reset state
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_id_valid", {31'h0, id_valid}, 32'h0);
    chk("rst_id_pc", id_pc, 32'h0);
    chk("rst_id_inst", id_inst, 32'h0);
    chk("rst_imem_req", {31'h0, imem_req}, 32'h0);
    chk("rst_fetch_stall", {31'h0, fetch_stall}, 32'h0);

    // Zero-wait sequential fetch
    rst_n = 1'b1;
    tick();
    chk("idle_to_req", {31'h0, imem_req}, 32'h1);
    chk("first_addr", imem_addr, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("seq_id_pc", id_pc, 32'(4 * i));
      chk("seq_id_valid", {31'h0, id_valid}, 32'h1);
      chk("seq_stall", {31'h0, fetch_stall}, 32'h0);
    end

    // BEQ at 0x10, imm=3: delay slot 0x14, then target 0x14+12 = 0x20
    tick();
    chk("beq_id_pc", id_pc, 32'h10);
    chk("beq_id_inst", id_inst, 32'h1000_0003);
    pc_src = PC_BRANCH;
    tick();
    pc_src = PC_NEXT;
    chk("beq_slot_pc", id_pc, 32'h14);
    chk("beq_tgt_addr", imem_addr, 32'h20);
    tick();
    chk("beq_tgt_id_pc", id_pc, 32'h20);

    // Two wait cycles per request
    lat = 2;
    for (int k = 0; k < 2; k++) begin
      for (int b = 0; b < 2; b++) begin
        tick();
        chk("wait_id_valid", {31'h0, id_valid}, 32'h0);
        chk("wait_stall", {31'h0, fetch_stall}, 32'h1);
        chk("wait_addr_hold", imem_addr, 32'h24 + 32'(4 * k));
      end
      tick();
      chk("wait_id_pc", id_pc, 32'h24 + 32'(4 * k));
      chk("wait_done_stall", {31'h0, fetch_stall}, 32'h0);
    end

    // JR to 0x103 (-> 0x100) while the delay-slot fetch waits 3 cycles
    lat = 3;
    pc_src = PC_JR;
    jr_data = 32'h0000_0103;
    tick();
    pc_src = PC_NEXT;
    chk("jr_bubble", {31'h0, id_valid}, 32'h0);
    chk("jr_redir_pend", {31'h0, dut.redir_pend}, 32'h1);
    tick();
    tick();
    tick();
    chk("jr_slot_pc", id_pc, 32'h2C);
    chk("jr_tgt_addr", imem_addr, 32'h100);
    chk("jr_pend_clr", {31'h0, dut.redir_pend}, 32'h0);
    lat = 0;
    tick();
    chk("jr_tgt_id_pc", id_pc, 32'h100);

    // Ack while stalled: park in F_HOLD, no refetch on release
    if_en = 1'b0;
    id_en = 1'b0;
    tick();
    chk("hold_req", {31'h0, imem_req}, 32'h0);
    chk("hold_id_pc", id_pc, 32'h100);
    tick();
    chk("hold_req2", {31'h0, imem_req}, 32'h0);
    chk("hold_valid", {31'h0, id_valid}, 32'h1);
    if_en = 1'b1;
    id_en = 1'b1;
    tick();
    chk("hold_rel_id_pc", id_pc, 32'h104);
    chk("hold_rel_inst", id_inst, 32'h2000_0104);
    chk("hold_rel_addr", imem_addr, 32'h108);

    // Flush of IF/ID does not stop pc
    id_rst = 1'b1;
    tick();
    id_rst = 1'b0;
    chk("flush_valid", {31'h0, id_valid}, 32'h0);
    chk("flush_addr", imem_addr, 32'h10C);

    // JR to 0xFFFF_FFFC, then wrap to 0
    tick();
    chk("wrap_pre_pc", id_pc, 32'h10C);
    pc_src = PC_JR;
    jr_data = 32'hFFFF_FFFF;
    tick();
    pc_src = PC_NEXT;
    chk("wrap_slot_pc", id_pc, 32'h110);
    chk("wrap_tgt_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("wrap_top_pc", id_pc, 32'hFFFF_FFFC);
    chk("wrap_addr", imem_addr, 32'h0);
    tick();
    chk("wrap_id_pc", id_pc, 32'h0);

    // Reset mid-wait, stale ack in F_IDLE ignored
    lat = 5;
    tick();
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'h0, id_valid}, 32'h0);
    chk("arst_req", {31'h0, imem_req}, 32'h0);
    mem_on = 1'b0;
    imem_ack = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    chk("stale_valid", {31'h0, id_valid}, 32'h0);
    chk("stale_req", {31'h0, imem_req}, 32'h1);
    chk("stale_addr", imem_addr, 32'h0);
    imem_ack = 1'b0;
    mem_on = 1'b1;
    lat = 0;
    wcnt = 0;
    tick();
    chk("post_rst_id_pc", id_pc, 32'h0);
    chk("post_rst_inst", id_inst, 32'h2000_0000);
    chk("post_rst_valid", {31'h0, id_valid}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
